lpffir_decim_axis: RTL
======================

// Module: lpffir_decim_axis
// PURPOSE
//  AXI-Stream decimate-by-DECIM stage that sits directly downstream of the LPF FIR core.
//  - Forwards one of every DECIM accepted samples. Frame boundaries (tlast) are preserved.
//  - A 2-entry output buffer keeps the FIR stage running under sporadic backpressure.
//  - Output is fully registered, so there is no combinational path from rx data to tx data.
// PARAMETERS
//  DW     16  sample width (signed two's complement, passed unmodified)
//  DECIM  4   decimation ratio, legal range 1..256 (DECIM=1 is pass-through with buffering)
// PORTS
//  aclk_i       in   1   clock; all logic is on the rising edge
//  aresetn_i    in   1   asynchronous active-low reset
//  rx_tvalid_i  in   1   upstream (FIR) beat valid
//  rx_tready_o  out  1   stage can accept a beat
//  rx_tdata_i   in   DW  filtered sample
//  rx_tlast_i   in   1   last sample of the frame
//  tx_tvalid_o  out  1   decimated beat valid
//  tx_tready_i  in   1   downstream ready
//  tx_tdata_o   out  DW  decimated sample
//  tx_tlast_o   out  1   last decimated sample of the frame
// BEHAVIOUR
//  Reset: all state clears asynchronously.
//   - tx_tvalid_o=0, tx_tdata_o=0, tx_tlast_o=0.
//   - Phase counter = 0, buffer count = 0, so rx_tready_o=1 once aresetn_i is high.
//  Handshake: a beat transfers when valid&&ready on the rising edge (rx side and tx side alike).
//   - rx_tready_o = (buf_cnt != 2). It depends only on registered state, never on tx_tready_i.
//   - Once tx_tvalid_o is asserted, it and tx_tdata_o/tx_tlast_o are held until tx_tready_i is sampled high.
//  Decimation: phase counter ph, width clog2(DECIM) (minimum 1 bit). It advances only on an accepted rx beat.
//   - Accepted beat is KEPT if ph==0 or rx_tlast_i==1; otherwise it is DROPPED (consumed, not stored).
//   - ph update: if rx_tlast_i, ph<=0; else if ph==DECIM-1, ph<=0; else ph<=ph+1.
//   - Result: the first sample of every frame is kept. The tlast beat is always kept, carrying tlast=1.
//   - A kept tlast beat that falls on phase 0 is emitted once, not twice.
//   - Dropped beats never set tx_tlast_o.
//  Buffer: 2-entry FIFO {tlast,data} with states EMPTY(0), ONE(1), FULL(2).
//   - EMPTY --push--> ONE; ONE --push&!pop--> FULL; ONE --pop&!push--> EMPTY; FULL --pop--> ONE.
//   - ONE with push and pop in the same cycle stays ONE. Push occurs only on a kept beat.
//   - FULL: rx_tready_o=0, so no push can collide with a pop. A pop frees the slot for the next cycle.
//   - tx_tvalid_o = (buf_cnt != 0). The head entry drives tx_tdata_o/tx_tlast_o from a register.
//  Latency: a kept beat accepted at edge N is visible on tx at edge N (valid from cycle N+1) when the buffer was EMPTY.
//   - Throughput: 1 kept beat per cycle when tx_tready_i is held high.
//  Boundaries:
//   - tx_tready_i=0 permanently: stage absorbs up to 2 kept beats plus any dropped beats seen before it fills, then stalls rx.
//   - Beats at ph!=0 are still only accepted when rx_tready_o=1, i.e. they also stall while FULL.
//   - Reset mid-frame: buffered beats are discarded and ph returns to 0. The next beat is treated as a frame start.
//   - DECIM=1: every beat is kept and the stage behaves as a 2-deep AXIS FIFO.
// TESTING
//  1 Reset: assert aresetn_i with tx_tvalid_o high -> tx_tvalid_o=0 and rx_tready_o=1 immediately; buffer empty after release.
//  2 DECIM=4, tx_tready_i=1, stream 0..11, tlast on 11 -> tx emits 0,4,8,11 with tlast only on 11; each appears 1 cycle after acceptance.
//  3 DECIM=4, frame 0..5 (tlast on 5), then frame 100..103 -> tx emits 0,4,5(last),100; ph restarts after tlast.
//  4 DECIM=4, tlast on beat 8 (phase 0) -> 8 is emitted exactly once with tlast=1.
//  5 DECIM=1, tx_tready_i=0, push 10,11,12 -> rx_tready_o drops after 11 and 12 waits; raise tx_tready_i -> 10,11,12 in order, no loss.
//  6 Random tx_tready_i (50%), 1000 beats, DECIM=3, random tlast -> matches the reference model (keep ph==0||tlast); tx data stable while stalled.

Source files
------------

// File: rtl/lpffir_decim_axis_if.sv
// AXI-Stream beat bundle used on both sides of the LPF FIR decimator.
// The master drives valid/data/last and the slave drives ready.
interface lpffir_decim_axis_if #(
    parameter int DW = 16
);
    logic          tvalid;
    logic          tready;
    logic [DW-1:0] tdata;
    logic          tlast;

    modport master (output tvalid, output tdata, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/lpffir_decim_axis.sv
// Decimate-by-DECIM AXI-Stream stage placed after the LPF FIR core.
// Keeps the first beat of every DECIM-beat group and every tlast beat, then
// queues kept beats in a 2-entry registered buffer so that tx outputs come
// straight from flops and rx_tready never depends on tx_tready.
module lpffir_decim_axis #(
    parameter int DW    = 16,
    parameter int DECIM = 4
) (
    input  logic                   aclk_i,
    input  logic                   aresetn_i,
    lpffir_decim_axis_if.slave     rx,
    lpffir_decim_axis_if.master    tx
);
    // Phase counter width; a DECIM of 1 still gets a 1-bit counter that stays at 0.
    localparam int            PW     = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [PW-1:0] PH_MAX = PW'(DECIM - 1);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } buf_state_t;

    buf_state_t    buf_state;
    logic [PW-1:0] ph;
    logic [DW-1:0] head_data;
    logic          head_last;
    logic [DW-1:0] tail_data;
    logic          tail_last;

    logic rx_fire;
    logic push;
    logic pop;

    // Ready and valid come only from the buffer state register.
    assign rx.tready = (buf_state != FULL);
    assign tx.tvalid = (buf_state != EMPTY);
    assign tx.tdata  = head_data;
    assign tx.tlast  = head_last;

    assign rx_fire = rx.tvalid && rx.tready;
    assign push    = rx_fire && ((ph == '0) || rx.tlast);
    assign pop     = tx.tvalid && tx.tready;

    // Phase counter: advances per accepted beat, restarts on frame end or wrap.
    // NOTE: state registers use non-blocking assignment so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge aclk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            ph <= '0;
        end else if (rx_fire) begin
            if (rx.tlast || (ph == PH_MAX)) begin
                ph <= '0;
            end else begin
                ph <= ph + 1'b1;
            end
        end
    end

    // Two-entry output buffer: head feeds tx directly, tail holds the overflow beat.
    // NOTE: the data slots are reset too, so tx_tdata/tx_tlast read 0 after
    // reset instead of stale contents.
    always_ff @(posedge aclk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            buf_state <= EMPTY;
            head_data <= '0;
            head_last <= 1'b0;
            tail_data <= '0;
            tail_last <= 1'b0;
        end else begin
            case (buf_state)
                EMPTY: begin
                    if (push) begin
                        head_data <= rx.tdata;
                        head_last <= rx.tlast;
                        buf_state <= ONE;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        head_data <= rx.tdata;
                        head_last <= rx.tlast;
                    end else if (push) begin
                        tail_data <= rx.tdata;
                        tail_last <= rx.tlast;
                        buf_state <= FULL;
                    end else if (pop) begin
                        buf_state <= EMPTY;
                    end
                end
                FULL: begin
                    // rx is stalled here, so only a pop can happen.
                    if (pop) begin
                        head_data <= tail_data;
                        head_last <= tail_last;
                        buf_state <= ONE;
                    end
                end
                default: begin
                    buf_state <= EMPTY;
                end
            endcase
        end
    end
endmodule
